// File: rtl/snd_cmd_mailbox_if.sv
// Bus between the main-CPU command path, the sound-CPU strobes and the mailbox.
// The master drives strobes and data; the mailbox (slave) returns head, status and INT.
interface snd_cmd_mailbox_if;
   logic       cmd_wr;
   logic [7:0] cmd_data;
   logic       snd_rd;
   logic       busy_clr;
   logic       fm_irq;
   logic       cmd_ack;
   logic       fm_ack;
   logic [7:0] cmd_dout;
   logic [7:0] status;
   logic       snd_busy;
   logic       cmd_full;
   logic       int_n;

   modport master (
      output cmd_wr, cmd_data, snd_rd, busy_clr, fm_irq, cmd_ack, fm_ack,
      input  cmd_dout, status, snd_busy, cmd_full, int_n
   );

   modport slave (
      input  cmd_wr, cmd_data, snd_rd, busy_clr, fm_irq, cmd_ack, fm_ack,
      output cmd_dout, status, snd_busy, cmd_full, int_n
   );
endinterface

// File: rtl/snd_cmd_mailbox.sv
// Sound-command FIFO mailbox with BUSY flag and a merged command/FM interrupt.
// Every output is a register or a decode of registers.
module snd_cmd_mailbox #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input logic           clk,
   input logic           RESETn,
   snd_cmd_mailbox_if.slave mb
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [AW:0]   count_q, count_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [7:0]    dout_q, dout_d;
   logic          busy_q, busy_d;
   logic          ovf_q, ovf_d;
   logic          cmd_pend_q, cmd_pend_d;
   logic          fm_pend_q, fm_pend_d;
   logic          fm_irq_q;
   logic          int_n_q, int_n_d;

   logic          pop, wr_acc, wr_drop, fm_rise;
   logic [4:0]    cnt_ext;
   logic [2:0]    cnt_sat;

   always_comb begin
      pop     = mb.snd_rd && (count_q != '0);
      // A pop frees a slot in the same cycle, so a full FIFO can still take a write.
      wr_acc  = mb.cmd_wr && ((count_q != FULL_CNT) || pop);
      wr_drop = mb.cmd_wr && !wr_acc;
      fm_rise = mb.fm_irq && !fm_irq_q;

      rd_ptr_d = pop    ? rd_ptr_q + AW'(1) : rd_ptr_q;
      wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;

      count_d = count_q;
      if (wr_acc && !pop)      count_d = count_q + (AW+1)'(1);
      else if (!wr_acc && pop) count_d = count_q - (AW+1)'(1);

      // The incoming byte becomes the head when it lands where rd_ptr will point.
      dout_d = 8'hFF;
      if (count_d != '0) begin
         if (wr_acc && (wr_ptr_q == rd_ptr_d)) dout_d = mb.cmd_data;
         else                                  dout_d = mem_q[rd_ptr_d];
      end

      // Set beats clear on every flag below.
      busy_d     = wr_acc  ? 1'b1 : (mb.busy_clr ? 1'b0 : busy_q);
      ovf_d      = wr_drop ? 1'b1 : (mb.busy_clr ? 1'b0 : ovf_q);
      cmd_pend_d = wr_acc  ? 1'b1 : (mb.cmd_ack  ? 1'b0 : cmd_pend_q);
      fm_pend_d  = fm_rise ? 1'b1 : (mb.fm_ack   ? 1'b0 : fm_pend_q);
      int_n_d    = ~(cmd_pend_d | fm_pend_d);
   end

   // NOTE: non-blocking assignments keep every register sampling pre-edge values.
   always_ff @(posedge clk) begin
      if (!RESETn) begin
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         dout_q     <= 8'hFF;
         busy_q     <= 1'b0;
         ovf_q      <= 1'b0;
         cmd_pend_q <= 1'b0;
         fm_pend_q  <= 1'b0;
         fm_irq_q   <= 1'b0;
         int_n_q    <= 1'b1;
      end else begin
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         dout_q     <= dout_d;
         busy_q     <= busy_d;
         ovf_q      <= ovf_d;
         cmd_pend_q <= cmd_pend_d;
         fm_pend_q  <= fm_pend_d;
         fm_irq_q   <= mb.fm_irq;
         int_n_q    <= int_n_d;
      end
   end

   // NOTE: storage has no reset; resetting the pointers and count discards its contents.
   always_ff @(posedge clk) begin
      if (wr_acc) mem_q[wr_ptr_q] <= mb.cmd_data;
   end

   always_comb begin
      cnt_ext = 5'(count_q);
      cnt_sat = (cnt_ext > 5'd7) ? 3'd7 : cnt_ext[2:0];
   end

   assign mb.cmd_dout = dout_q;
   assign mb.status   = {ovf_q, 2'b00, cnt_sat, fm_pend_q, cmd_pend_q};
   assign mb.snd_busy = busy_q;
   assign mb.cmd_full = (count_q == FULL_CNT);
   assign mb.int_n    = int_n_q;

endmodule
